// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory bridge: FSM states, the latched
// bus command, the default wait limit and byte-lane selection.
package dmem_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   localparam int unsigned TIMEOUT_DEFAULT = 255;

   // Everything the bus needs, captured once when the core request is accepted.
   typedef struct packed {
      logic        we;
      logic        is_byte;
      logic [1:0]  lane;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
   } bus_cmd_t;

   function automatic logic [3:0] lane_be(input logic is_byte, input logic [1:0] lane);
      logic [3:0] be;
      if (is_byte) be = 4'b0001 << lane;
      else         be = 4'b1111;
      return be;
   endfunction

   function automatic logic [31:0] word_addr(input logic [31:0] a);
      return {a[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/dmem_bridge_if.sv
// Single-outstanding request/ack memory bus between the bridge (master) and
// the memory or interconnect (slave).
interface dmem_bridge_if;

   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [3:0]  bus_be;
   logic [31:0] bus_wdata;
   logic        bus_ack;
   logic [31:0] bus_rdata;

   modport master (
      output bus_req,
      output bus_we,
      output bus_addr,
      output bus_be,
      output bus_wdata,
      input  bus_ack,
      input  bus_rdata
   );

   modport slave (
      input  bus_req,
      input  bus_we,
      input  bus_addr,
      input  bus_be,
      input  bus_wdata,
      output bus_ack,
      output bus_rdata
   );

endinterface

// File: rtl/byte_lane.sv
// Combinational byte-lane steering: store-side enables and replicated data from
// the core request, load-side lane extraction from the returned bus word.
module byte_lane
   import dmem_pkg::*;
(
   input  logic        wr_byte,
   input  logic [1:0]  wr_lane,
   input  logic [31:0] wr_data,
   output logic [3:0]  wr_be,
   output logic [31:0] wr_bus_data,
   input  logic        rd_byte,
   input  logic [1:0]  rd_lane,
   input  logic [31:0] rd_bus_data,
   output logic [31:0] rd_data
);

   always_comb begin
      wr_be       = lane_be(wr_byte, wr_lane);
      wr_bus_data = wr_data;
      if (wr_byte) wr_bus_data = {4{wr_data[7:0]}};
   end

   // Little-endian: lane 0 is bits [7:0]; byte loads are zero-extended.
   always_comb begin
      rd_data = rd_bus_data;
      if (rd_byte) rd_data = {24'h00_0000, rd_bus_data[{rd_lane, 3'b000} +: 8]};
   end

endmodule

// File: rtl/dmem_bridge.sv
// Bridges the core's single-cycle load/store port onto a request/ack bus,
// stalling the core until the transfer completes or the wait limit expires.
module dmem_bridge
   import dmem_pkg::*;
#(
   parameter int unsigned TIMEOUT  = TIMEOUT_DEFAULT,
   parameter logic [31:0] ERR_DATA = 32'h0000_0000
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          mem_write,
   input  logic          mem_read,
   input  logic          mem_byte,
   input  logic [31:0]   addr,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata,
   output logic          stall,
   output logic          err,
   dmem_bridge_if.master bus
);

   localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
   bus_cmd_t         cmd_q, cmd_d;
   logic [31:0]      rdata_q, rdata_d;
   logic             err_q, err_d;
   logic             req_in;
   logic [3:0]       lane_be_w;
   logic [31:0]      lane_wdata_w;
   logic [31:0]      lane_rdata_w;

   byte_lane u_byte_lane (
      .wr_byte     (mem_byte),
      .wr_lane     (addr[1:0]),
      .wr_data     (wdata),
      .wr_be       (lane_be_w),
      .wr_bus_data (lane_wdata_w),
      .rd_byte     (cmd_q.is_byte),
      .rd_lane     (cmd_q.lane),
      .rd_bus_data (bus.bus_rdata),
      .rd_data     (lane_rdata_w)
   );

   assign req_in  = mem_read | mem_write;
   assign cnt_inc = cnt_q + CNT_W'(1);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      cmd_d   = cmd_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      stall   = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            stall = req_in;
            if (req_in) begin
               // A combined read+write is taken as a store.
               cmd_d.we      = mem_write;
               cmd_d.is_byte = mem_byte;
               cmd_d.lane    = addr[1:0];
               cmd_d.addr    = word_addr(addr);
               cmd_d.be      = lane_be_w;
               cmd_d.wdata   = lane_wdata_w;
               cnt_d         = '0;
               state_d       = ST_BUSY;
            end
         end
         ST_BUSY: begin
            stall = 1'b1;
            if (bus.bus_ack) begin
               if (!cmd_q.we) rdata_d = lane_rdata_w;
               state_d = ST_DONE;
            end else if (cnt_inc == CNT_LIMIT) begin
               // Give up; an ack arriving on this same cycle would have won above.
               cnt_d   = cnt_inc;
               err_d   = 1'b1;
               if (!cmd_q.we) rdata_d = ERR_DATA;
               state_d = ST_DONE;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         cmd_q   <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         cmd_q   <= cmd_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   // Bus outputs come straight from registers so they stay stable through BUSY.
   assign bus.bus_req   = (state_q == ST_BUSY);
   assign bus.bus_we    = cmd_q.we;
   assign bus.bus_addr  = cmd_q.addr;
   assign bus.bus_be    = cmd_q.be;
   assign bus.bus_wdata = cmd_q.wdata;
   assign rdata         = rdata_q;
   assign err           = err_q;

endmodule

// File: tb/tb_dmem_bridge.sv
// Randomized scoreboard bench for dmem_bridge: the driver acts as core and
// schedules memory responses, a monitor checks bus commands and completions.
module tb_dmem_bridge;

   localparam int          TO    = 4;
   localparam logic [31:0] ERR_D = 32'hDEAD_BEEF;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
   } bus_exp_t;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          busy;
   } done_exp_t;

   typedef struct {
      int          k;
      logic [31:0] data;
   } resp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        mem_write, mem_read, mem_byte;
   logic [31:0] addr, wdata, rdata;
   logic        stall, err;

   logic        rsp_ack  = 1'b0;
   logic        late_ack = 1'b0;
   logic [31:0] rsp_data = 32'h0;
   bit          abort_flag = 1'b0;

   int n_chk  = 0;
   int n_pass = 0;

   bus_exp_t  exp_bus_q[$];
   done_exp_t exp_done_q[$];
   resp_t     resp_q[$];

   logic [31:0] model_rdata = 32'h0;
   logic        model_err   = 1'b0;

   always #5 clk = ~clk;

   dmem_bridge_if bus_if ();

   assign bus_if.bus_ack   = rsp_ack | late_ack;
   assign bus_if.bus_rdata = rsp_data;

   dmem_bridge #(.TIMEOUT(TO), .ERR_DATA(ERR_D)) dut (
      .clk       (clk),
      .reset     (reset),
      .mem_write (mem_write),
      .mem_read  (mem_read),
      .mem_byte  (mem_byte),
      .addr      (addr),
      .wdata     (wdata),
      .rdata     (rdata),
      .stall     (stall),
      .err       (err),
      .bus       (bus_if)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
   endtask

   task automatic fail_now(input string name);
      n_chk++;
      $display("FAIL %s: expected event missing (got none, required one)", name);
   endtask

   // Memory responder: acks on the k-th cycle bus_req is seen high (k=0: never).
   resp_t rsp_cur;
   bit    rsp_active = 1'b0;
   int    rsp_cnt    = 0;
   always begin
      @(negedge clk);
      rsp_ack = 1'b0;
      if (bus_if.bus_req) begin
         if (!rsp_active) begin
            rsp_active = 1'b1;
            rsp_cnt    = 0;
            if (resp_q.size() != 0) rsp_cur = resp_q.pop_front();
            else begin rsp_cur.k = 0; rsp_cur.data = 32'h0; end
         end
         rsp_cnt++;
         if (rsp_cnt == rsp_cur.k) begin
            rsp_ack  = 1'b1;
            rsp_data = rsp_cur.data;
         end
      end else begin
         rsp_active = 1'b0;
      end
   end

   // Monitor: checks each bus command while it is presented and each completion.
   bus_exp_t  mon_bus;
   done_exp_t mon_done;
   bit        prev_req   = 1'b0;
   bit        prev_stall = 1'b0;
   int        stall_cnt  = 0;
   int        req_cnt    = 0;
   always begin
      @(negedge clk);
      if (!reset || abort_flag) begin
         prev_req   = bus_if.bus_req;
         prev_stall = stall;
         stall_cnt  = 0;
         req_cnt    = 0;
      end else begin
         if (bus_if.bus_req) begin
            if (!prev_req) begin
               req_cnt = 0;
               if (exp_bus_q.size() != 0) mon_bus = exp_bus_q.pop_front();
               else fail_now("unexpected_bus_req");
            end
            req_cnt++;
            chk("bus_we",    32'(bus_if.bus_we), 32'(mon_bus.we));
            chk("bus_addr",  bus_if.bus_addr,    mon_bus.addr);
            chk("bus_be",    32'(bus_if.bus_be), 32'(mon_bus.be));
            chk("bus_wdata", bus_if.bus_wdata,   mon_bus.wdata);
         end
         if (stall) begin
            stall_cnt++;
         end else if (prev_stall) begin
            if (exp_done_q.size() != 0) begin
               mon_done = exp_done_q.pop_front();
               chk("done_rdata",     rdata,                 mon_done.rdata);
               chk("done_err",       32'(err),              32'(mon_done.err));
               chk("stall_cycles",   32'(stall_cnt),        32'(mon_done.busy + 1));
               chk("bus_req_cycles", 32'(req_cnt),          32'(mon_done.busy));
               chk("done_bus_req",   32'(bus_if.bus_req),   32'd0);
            end else begin
               fail_now("unexpected_completion");
            end
            stall_cnt = 0;
         end
         prev_req   = bus_if.bus_req;
         prev_stall = stall;
      end
   end

   // Reference model of one core access; ack on busy cycle k (0 = no ack).
   task automatic do_txn(input bit wr, input bit rd, input bit byt, input logic [31:0] a,
                         input logic [31:0] wd, input int k, input logic [31:0] brd,
                         input bit keep);
      bus_exp_t  be_e;
      done_exp_t de;
      resp_t     r;
      int        lane;
      int        busy;
      bit        done;
      lane       = int'(a % 32'd4);
      be_e.we    = wr;
      be_e.addr  = a - (a % 32'd4);
      be_e.be    = byt ? 4'(1 << lane) : 4'hF;
      be_e.wdata = byt ? (32'(wd[7:0]) * 32'h0101_0101) : wd;
      if (k >= 1 && k <= TO) begin
         busy = k;
         if (!wr) model_rdata = byt ? ((brd >> (8 * lane)) & 32'h0000_00FF) : brd;
      end else begin
         busy      = TO;
         model_err = 1'b1;
         if (!wr) model_rdata = ERR_D;
      end
      de.rdata = model_rdata;
      de.err   = model_err;
      de.busy  = busy;
      r.k      = k;
      r.data   = brd;
      exp_bus_q.push_back(be_e);
      exp_done_q.push_back(de);
      resp_q.push_back(r);
      mem_write = wr;
      mem_read  = rd;
      mem_byte  = byt;
      addr      = a;
      wdata     = wd;
      done      = 1'b0;
      for (int i = 0; i < 64 && !done; i++) begin
         @(posedge clk); #1;
         if (!stall) done = 1'b1;
      end
      if (!done) fail_now("txn_completion");
      if (!keep) begin
         mem_write = 1'b0;
         mem_read  = 1'b0;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got no finish, required finish within budget");
      $fatal(1, "watchdog");
   end

   int sel;
   bit w, r;

   initial begin
      reset = 1'b0; mem_write = 1'b0; mem_read = 1'b0; mem_byte = 1'b0;
      addr = 32'h0; wdata = 32'h0;
      #3;
      chk("rst_bus_req",   32'(bus_if.bus_req), 32'd0);
      chk("rst_bus_we",    32'(bus_if.bus_we),  32'd0);
      chk("rst_bus_be",    32'(bus_if.bus_be),  32'd0);
      chk("rst_bus_addr",  bus_if.bus_addr,     32'd0);
      chk("rst_bus_wdata", bus_if.bus_wdata,    32'd0);
      chk("rst_rdata",     rdata,               32'd0);
      chk("rst_err",       32'(err),            32'd0);
      chk("rst_stall",     32'(stall),          32'd0);
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;

      do_txn(1'b1, 1'b0, 1'b0, 32'h0000_0100, 32'hCAFE_BABE, 3, $urandom, 1'b0);
      do_txn(1'b1, 1'b0, 1'b1, 32'h0000_0103, 32'h0000_00A5, 2, $urandom, 1'b0);
      do_txn(1'b0, 1'b1, 1'b1, 32'h0000_0202, $urandom, 1, 32'h1122_3344, 1'b0);
      chk("byte_load_rdata", rdata, 32'h0000_0022);
      @(posedge clk); #1;
      chk("rdata_hold_idle", rdata, 32'h0000_0022);
      do_txn(1'b1, 1'b1, 1'b0, 32'h0000_0208, 32'h1357_9BDF, 2, 32'hFFFF_FFFF, 1'b0);
      do_txn(1'b0, 1'b1, 1'b0, 32'h0000_0300, $urandom, 2, $urandom, 1'b1);
      do_txn(1'b1, 1'b0, 1'b0, 32'h0000_0304, $urandom, 1, $urandom, 1'b0);

      for (int i = 0; i < 40; i++) begin
         sel = int'($urandom_range(0, 2));
         w   = (sel != 0);
         r   = (sel != 1);
         do_txn(w, r, 1'($urandom_range(0, 1)), $urandom, $urandom,
                int'($urandom_range(1, TO)), $urandom, (i != 39) && ($urandom_range(0, 1) == 1));
      end
      @(posedge clk); #1;

      do_txn(1'b0, 1'b1, 1'b0, 32'h0000_0400, $urandom, 0, $urandom, 1'b0);
      chk("timeout_err",   32'(err), 32'd1);
      chk("timeout_rdata", rdata,    ERR_D);
      do_txn(1'b0, 1'b1, 1'b0, 32'h0000_0404, $urandom, 2, 32'h0BAD_F00D, 1'b0);
      chk("err_sticky", 32'(err), 32'd1);
      do_txn(1'b0, 1'b1, 1'b1, 32'h0000_0409, $urandom, TO, 32'hA1B2_C3D4, 1'b0);
      @(posedge clk); #1;

      // Reset in the middle of a transfer, then a stray ack after release.
      begin
         bus_exp_t  be_e;
         resp_t     rr;
         be_e.we = 1'b0; be_e.addr = 32'h0000_0500; be_e.be = 4'hF; be_e.wdata = 32'h0;
         rr.k = 0; rr.data = 32'h0;
         exp_bus_q.push_back(be_e);
         resp_q.push_back(rr);
         mem_read = 1'b1; mem_byte = 1'b0; addr = 32'h0000_0500; wdata = 32'h0;
         @(posedge clk); #1;
         @(posedge clk); #1;
         chk("abort_pre_busy", 32'(bus_if.bus_req), 32'd1);
         abort_flag = 1'b1;
         reset = 1'b0;
         #1;
         chk("abort_bus_req", 32'(bus_if.bus_req), 32'd0);
         chk("abort_rdata",   rdata,               32'd0);
         chk("abort_err",     32'(err),            32'd0);
         chk("abort_bus_be",  32'(bus_if.bus_be),  32'd0);
         mem_read = 1'b0;
         #1;
         chk("abort_stall", 32'(stall), 32'd0);
         @(posedge clk); #1;
         reset    = 1'b1;
         late_ack = 1'b1;
         @(posedge clk); #1;
         late_ack = 1'b0;
         chk("late_ack_bus_req", 32'(bus_if.bus_req), 32'd0);
         chk("late_ack_stall",   32'(stall),          32'd0);
         chk("late_ack_rdata",   rdata,               32'd0);
         @(posedge clk); #1;
         chk("late_ack_idle", 32'(bus_if.bus_req), 32'd0);
         model_err   = 1'b0;
         model_rdata = 32'h0;
         abort_flag  = 1'b0;
      end

      do_txn(1'b0, 1'b1, 1'b0, 32'h0000_0600, $urandom, 2, 32'h7654_3210, 1'b0);
      repeat (4) @(posedge clk);
      #1;
      chk("bus_q_drained",  32'(exp_bus_q.size()),  32'd0);
      chk("done_q_drained", 32'(exp_done_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
